// File: rtl/usb_nrzi_tx.sv
// -----------------------------------------------------------------------------
// usb_nrzi_tx
//   USB transmit line encoder. Takes the stuffed serial bitstream (one bit per
//   clock) from the bit stuffer, NRZI-encodes it onto the D+/D- pair as J/K
//   states, appends End-of-Packet (SE0 for EOP_SE0_BITS bit times, then one J)
//   on request, and returns the line to idle J with the driver disabled.
//   One clk cycle is one bit time. All outputs are registered.
//
// Parameters
//   LOW_SPEED     0: J = (dp=1, dm=0); 1: J = (dp=0, dm=1). K is the inverse.
//   EOP_SE0_BITS  number of SE0 bit times in the EOP (1..7).
//
// Ports
//   clk       in   bit-rate clock
//   nRST      in   asynchronous active-low reset
//   in_bit    in   stuffed data bit
//   in_valid  in   in_bit carries a bit this cycle
//   eop_req   in   single-cycle EOP request after the last data bit
//   tx_dp     out  D+ drive value
//   tx_dm     out  D- drive value
//   tx_oe     out  output-driver enable
//   eop_done  out  pulse while the final EOP J is driven
//   tx_err    out  pulse on a protocol violation (stray eop_req / late bit)
// -----------------------------------------------------------------------------
module usb_nrzi_tx #(
    parameter bit          LOW_SPEED    = 1'b0,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic nRST,
    input  logic in_bit,
    input  logic in_valid,
    input  logic eop_req,
    output logic tx_dp,
    output logic tx_dm,
    output logic tx_oe,
    output logic eop_done,
    output logic tx_err
);

    localparam logic       J_DP     = !LOW_SPEED;
    localparam logic       J_DM     = LOW_SPEED;
    localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t     state;
    logic       nrzi_level;   // 1 = J, 0 = K
    logic       eop_pend;
    logic [2:0] se0_cnt;
    logic       next_level;

    // Line pair {dp, dm} for an NRZI level.
    function automatic logic [1:0] line_pair(input logic level);
        return level ? {J_DP, J_DM} : {!J_DP, !J_DM};
    endfunction

    // NRZI: a 0 toggles the line, a 1 holds it.
    assign next_level = in_bit ? nrzi_level : !nrzi_level;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            nrzi_level     <= 1'b1;
            eop_pend       <= 1'b0;
            se0_cnt        <= 3'd0;
            {tx_dp, tx_dm} <= line_pair(1'b1);
            tx_oe          <= 1'b0;
            eop_done       <= 1'b0;
            tx_err         <= 1'b0;
        end else begin
            eop_done <= 1'b0;
            tx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    {tx_dp, tx_dm} <= line_pair(1'b1);
                    tx_oe          <= 1'b0;
                    // EOP with no packet in flight is meaningless; flag it.
                    tx_err         <= eop_req;
                    if (in_valid) begin
                        // Encoding starts from J, so the new level equals the bit.
                        state          <= DATA;
                        tx_oe          <= 1'b1;
                        nrzi_level     <= in_bit;
                        {tx_dp, tx_dm} <= line_pair(in_bit);
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        nrzi_level     <= next_level;
                        {tx_dp, tx_dm} <= line_pair(next_level);
                        if (eop_req) eop_pend <= 1'b1;
                    end else if (eop_pend) begin
                        // Stuffer has drained: begin the SE0 run.
                        state          <= EOP_SE0;
                        se0_cnt        <= 3'd1;
                        {tx_dp, tx_dm} <= 2'b00;
                    end else if (eop_req) begin
                        eop_pend <= 1'b1;
                    end
                    // in_valid low with nothing pending: pair is held (stall).
                end
                EOP_SE0: begin
                    tx_err <= in_valid;
                    if (se0_cnt == SE0_LAST) begin
                        state          <= EOP_J;
                        {tx_dp, tx_dm} <= line_pair(1'b1);
                        eop_done       <= 1'b1;
                    end else begin
                        se0_cnt        <= se0_cnt + 3'd1;
                        {tx_dp, tx_dm} <= 2'b00;
                    end
                end
                EOP_J: begin
                    tx_err         <= in_valid;
                    state          <= IDLE;
                    tx_oe          <= 1'b0;
                    eop_pend       <= 1'b0;
                    nrzi_level     <= 1'b1;
                    se0_cnt        <= 3'd0;
                    {tx_dp, tx_dm} <= line_pair(1'b1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
module tb_usb_nrzi_tx;

    logic clk;
    logic nRST;
    logic in_bit, in_valid, eop_req;
    logic dp0, dm0, oe0, done0, err0;
    logic dp1, dm1, oe1, done1, err1;

    int checks   = 0;
    int failures = 0;

    localparam int S_IDLE = 0, S_DATA = 1, S_SE0 = 2, S_J = 3;

    // Reference model state, index 0 = full speed / 2 SE0, 1 = low speed / 3 SE0.
    int   m_st [2];
    int   m_cnt[2];
    logic m_lvl[2], m_pend[2], m_dp[2], m_dm[2], m_oe[2];

    logic [4:0] q0[$];
    logic [4:0] q1[$];

    logic [7:0]  sdp0, sdp1;
    logic [19:0] eop_seq;

    usb_nrzi_tx #(.LOW_SPEED(1'b0), .EOP_SE0_BITS(2)) dut0 (
        .clk(clk), .nRST(nRST), .in_bit(in_bit), .in_valid(in_valid), .eop_req(eop_req),
        .tx_dp(dp0), .tx_dm(dm0), .tx_oe(oe0), .eop_done(done0), .tx_err(err0)
    );

    usb_nrzi_tx #(.LOW_SPEED(1'b1), .EOP_SE0_BITS(3)) dut1 (
        .clk(clk), .nRST(nRST), .in_bit(in_bit), .in_valid(in_valid), .eop_req(eop_req),
        .tx_dp(dp1), .tx_dm(dm1), .tx_oe(oe1), .eop_done(done1), .tx_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = S_IDLE; m_cnt[i] = 0; m_lvl[i] = 1'b1; m_pend[i] = 1'b0;
            m_oe[i] = 1'b0;
            m_dp[i] = (i == 0); m_dm[i] = (i != 0);
        end
        q0.delete();
        q1.delete();
    endtask

    // Behavioural line model; pushes the expected registered outputs.
    task automatic model_step(input int i, input int n, input logic b, input logic v, input logic r);
        logic jdp, jdm, done, err;
        jdp  = (i == 0);
        jdm  = (i != 0);
        done = 1'b0;
        err  = 1'b0;
        case (m_st[i])
            S_IDLE: begin
                err = r; m_oe[i] = 1'b0; m_dp[i] = jdp; m_dm[i] = jdm;
                if (v) begin
                    m_st[i] = S_DATA; m_oe[i] = 1'b1; m_lvl[i] = b;
                    m_dp[i] = b ? jdp : !jdp; m_dm[i] = b ? jdm : !jdm;
                end
            end
            S_DATA: begin
                if (v) begin
                    if (!b) m_lvl[i] = !m_lvl[i];
                    m_dp[i] = m_lvl[i] ? jdp : !jdp; m_dm[i] = m_lvl[i] ? jdm : !jdm;
                    if (r) m_pend[i] = 1'b1;
                end else if (m_pend[i]) begin
                    m_st[i] = S_SE0; m_cnt[i] = 1; m_dp[i] = 1'b0; m_dm[i] = 1'b0;
                end else if (r) begin
                    m_pend[i] = 1'b1;
                end
            end
            S_SE0: begin
                err = v;
                if (m_cnt[i] == n) begin
                    m_st[i] = S_J; m_dp[i] = jdp; m_dm[i] = jdm; done = 1'b1;
                end else begin
                    m_cnt[i]++;
                end
            end
            default: begin
                err = v; m_st[i] = S_IDLE; m_oe[i] = 1'b0; m_pend[i] = 1'b0;
                m_lvl[i] = 1'b1; m_dp[i] = jdp; m_dm[i] = jdm;
            end
        endcase
        if (i == 0) q0.push_back({m_dp[i], m_dm[i], m_oe[i], done, err});
        else        q1.push_back({m_dp[i], m_dm[i], m_oe[i], done, err});
    endtask

    task automatic cycle(input logic b, input logic v, input logic r);
        logic [4:0] e;
        in_bit = b; in_valid = v; eop_req = r;
        model_step(0, 2, b, v, r);
        model_step(1, 3, b, v, r);
        @(posedge clk);
        #1;
        if (q0.size() == 0) chk("sb0_underflow", 32'd0, 32'd1);
        else begin e = q0.pop_front(); chk("line_ls0", {dp0, dm0, oe0, done0, err0}, e); end
        if (q1.size() == 0) chk("sb1_underflow", 32'd0, 32'd1);
        else begin e = q1.pop_front(); chk("line_ls1", {dp1, dm1, oe1, done1, err1}, e); end
        eop_seq = {eop_seq[15:0], dp0, dm0, oe0, done0};
    endtask

    initial begin
        nRST = 1'b0; in_bit = 1'b0; in_valid = 1'b0; eop_req = 1'b0;
        eop_seq = '0; sdp0 = '0; sdp1 = '0;
        #12;
        chk("reset_ls0", {dp0, dm0, oe0, done0, err0}, 5'b10000);
        chk("reset_ls1", {dp1, dm1, oe1, done1, err1}, 5'b01000);
        @(negedge clk);
        nRST = 1'b1;
        model_reset();

        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // SYNC pattern
        for (int i = 0; i < 8; i++) begin
            cycle((i == 7), 1'b1, 1'b0);
            sdp0[7-i] = dp0;
            sdp1[7-i] = dp1;
        end
        chk("sync_dp_ls0", sdp0, 8'b0101_0100);
        chk("sync_dp_ls1", sdp1, 8'b1010_1011);

        // data, 3-cycle stall, data, then EOP request after the last bit
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        // SE0, SE0, J, idle, then next packet's first 0 one cycle after EOP_J
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("eop_seq_ls0", eop_seq, 20'b0010_0010_1011_1000_0110);

        // collision: last bit together with eop_req, then a bit during SE0
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("se0_late_bit_ls0", {dp0, dm0, oe0, err0}, 4'b0011);
        repeat (6) cycle(1'b0, 1'b0, 1'b0);

        // stray eop_req while idle
        cycle(1'b0, 1'b0, 1'b1);
        chk("stray_eop_ls0", {dp0, dm0, oe0, done0, err0}, 5'b10001);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
        repeat (8) cycle(1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-packet
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_ls0", {dp0, dm0, oe0, done0, err0}, 5'b10000);
        chk("async_rst_ls1", {dp1, dm1, oe1, done1, err1}, 5'b01000);
        @(posedge clk);
        #1;
        chk("rst_hold_ls0", {dp0, dm0, oe0}, 3'b100);
        @(negedge clk);
        nRST = 1'b1;
        model_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
